alu_packet_engine: RTL

ALU_PACKET_ENGINE -- requirements
Module: alu_packet_engine

---
 rtl/alu_packet_engine.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_packet_engine.sv
// alu_packet_engine: parses framed byte packets from a UART-style stream and either
// echoes the payload, folds it into an ADD/MUL accumulator whose result is sent back
// LSB first, or drops it. A single output register feeds the outbound byte stream.
module alu_packet_engine #(
    parameter int unsigned WIDTH_P  = 32,
    parameter bit          MUL_EN_P = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] in_data_i,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    output logic [7:0] out_data_o,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output logic       busy_o,
    output logic       err_o
);

    localparam int unsigned NB      = WIDTH_P / 8;
    localparam logic [2:0]  LastIdx = 3'(NB - 1);
    localparam logic [3:0]  NbCnt   = 4'(NB);
    localparam logic [7:0]  OpEcho  = 8'hEC;
    localparam logic [7:0]  OpAdd   = 8'hAD;
    localparam logic [7:0]  OpMul   = 8'h88;

    typedef enum logic [2:0] {StHdr, StEcho, StAcc, StDrop, StEmit} state_e;

    state_e               state_q, state_d;
    logic [1:0]           hdr_cnt_q, hdr_cnt_d;
    logic [7:0]           op_q, op_d;
    logic [7:0]           len_lo_q, len_lo_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [2:0]           byte_idx_q, byte_idx_d;
    logic [WIDTH_P-1:0]   opnd_q, opnd_d;
    logic [WIDTH_P-1:0]   acc_q, acc_d;
    logic                 is_mul_q, is_mul_d;
    logic                 misalign_q, misalign_d;
    logic [3:0]           emit_cnt_q, emit_cnt_d;
    logic [7:0]           out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic                 err_q, err_d;

    logic                 accept;
    logic [15:0]          len_full;
    logic [15:0]          payload_len;
    logic [WIDTH_P-1:0]   full_opnd;
    logic                 op_acc;
    logic                 op_known;

    assign accept      = in_valid_i && in_ready_o;
    assign len_full    = {in_data_i, len_lo_q};
    assign payload_len = len_full - 16'd4;
    // Operand with the current byte merged in at its little-endian position.
    assign full_opnd   = opnd_q | (WIDTH_P'(in_data_i) << {byte_idx_q, 3'b000});
    assign op_acc      = (op_q == OpAdd) || (MUL_EN_P && (op_q == OpMul));
    assign op_known    = op_acc || (op_q == OpEcho);

    assign out_data_o  = out_data_q;
    assign out_valid_o = out_valid_q;
    assign err_o       = err_q;
    assign busy_o      = !((state_q == StHdr) && (hdr_cnt_q == 2'd0) && !out_valid_q);

    // Input handshake: echo is throttled by the output register, emit accepts nothing.
    always_comb begin
        in_ready_o = 1'b1;
        unique case (state_q)
            StEcho:  in_ready_o = !out_valid_q || out_ready_i;
            StEmit:  in_ready_o = 1'b0;
            default: in_ready_o = 1'b1;
        endcase
    end

    // Next-state logic for the packet parser, accumulator and output register.
    always_comb begin
        state_d     = state_q;
        hdr_cnt_d   = hdr_cnt_q;
        op_d        = op_q;
        len_lo_d    = len_lo_q;
        cnt_d       = cnt_q;
        byte_idx_d  = byte_idx_q;
        opnd_d      = opnd_q;
        acc_d       = acc_q;
        is_mul_d    = is_mul_q;
        misalign_d  = misalign_q;
        emit_cnt_d  = emit_cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        err_d       = 1'b0;

        // A byte left over from an echo drains in any state that does not reload it.
        if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            StHdr: begin
                if (accept) begin
                    unique case (hdr_cnt_q)
                        2'd0: begin
                            op_d      = in_data_i;
                            hdr_cnt_d = 2'd1;
                        end
                        2'd1: hdr_cnt_d = 2'd2;
                        2'd2: begin
                            len_lo_d  = in_data_i;
                            hdr_cnt_d = 2'd3;
                        end
                        default: begin
                            hdr_cnt_d = 2'd0;
                            cnt_d     = payload_len;
                            if (len_full <= 16'd4) begin
                                err_d = (len_full < 16'd4) || !op_known;
                            end else if (op_q == OpEcho) begin
                                state_d = StEcho;
                            end else if (op_acc) begin
                                state_d    = StAcc;
                                is_mul_d   = (op_q == OpMul);
                                acc_d      = (op_q == OpMul) ? WIDTH_P'(1) : '0;
                                opnd_d     = '0;
                                byte_idx_d = 3'd0;
                                misalign_d = (payload_len & 16'(NB - 1)) != 16'd0;
                            end else begin
                                state_d = StDrop;
                            end
                        end
                    endcase
                end
            end
            StEcho: begin
                if (accept) begin
                    out_data_d  = in_data_i;
                    out_valid_d = 1'b1;
                    cnt_d       = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) begin
                        state_d = StHdr;
                    end
                end
            end
            StAcc: begin
                if (accept) begin
                    cnt_d = cnt_q - 16'd1;
                    if (byte_idx_q == LastIdx) begin
                        acc_d      = is_mul_q ? acc_q * full_opnd : acc_q + full_opnd;
                        opnd_d     = '0;
                        byte_idx_d = 3'd0;
                    end else begin
                        opnd_d     = full_opnd;
                        byte_idx_d = byte_idx_q + 3'd1;
                    end
                    if (cnt_q == 16'd1) begin
                        if (misalign_q) begin
                            err_d   = 1'b1;
                            state_d = StHdr;
                        end else begin
                            state_d    = StEmit;
                            emit_cnt_d = 4'd0;
                        end
                    end
                end
            end
            StDrop: begin
                if (accept) begin
                    cnt_d = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) begin
                        err_d   = 1'b1;
                        state_d = StHdr;
                    end
                end
            end
            StEmit: begin
                // The accumulator is shifted out through the output register, LSB first.
                if (out_valid_q && out_ready_i && (emit_cnt_q == NbCnt)) begin
                    out_valid_d = 1'b0;
                    state_d     = StHdr;
                end else if ((!out_valid_q || out_ready_i) && (emit_cnt_q != NbCnt)) begin
                    out_data_d  = acc_q[7:0];
                    out_valid_d = 1'b1;
                    acc_d       = acc_q >> 8;
                    emit_cnt_d  = emit_cnt_q + 4'd1;
                end
            end
            default: state_d = StHdr;
        endcase
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StHdr;
            hdr_cnt_q   <= 2'd0;
            op_q        <= 8'd0;
            len_lo_q    <= 8'd0;
            cnt_q       <= 16'd0;
            byte_idx_q  <= 3'd0;
            opnd_q      <= '0;
            acc_q       <= '0;
            is_mul_q    <= 1'b0;
            misalign_q  <= 1'b0;
            emit_cnt_q  <= 4'd0;
            out_data_q  <= 8'd0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hdr_cnt_q   <= hdr_cnt_d;
            op_q        <= op_d;
            len_lo_q    <= len_lo_d;
            cnt_q       <= cnt_d;
            byte_idx_q  <= byte_idx_d;
            opnd_q      <= opnd_d;
            acc_q       <= acc_d;
            is_mul_q    <= is_mul_d;
            misalign_q  <= misalign_d;
            emit_cnt_q  <= emit_cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

endmodule
